manual_drive_ctrl: RTL and testbench

- Power and manual-driving controller for the simulated car.
- Converts the panel inputs (power buttons, clutch, throttle, brake, reverse switch, left/right turn) into an engine power flag, a 2-bit drive state and a 4-bit moving-state nibble. The parent places that nibble in bits [3:0] of the UART byte sent to the simulator.
- Also drives the blinking turn-indicator lights.

---
 rtl/manual_drive_ctrl.sv | 151 +++++++++++++++
 tb/tb_manual_drive_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/manual_drive_ctrl.sv
// Engine power and manual-drive controller: turns panel inputs into power, drive state,
// the moving-state nibble for the simulator link, and blinking turn indicators.
module manual_drive_ctrl #(
    parameter int POWER_ON_HOLD = 100_000_000,
    parameter int BLINK_HALF    = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic       power_off,
    input  logic       clutch,
    input  logic       throttle,
    input  logic       brake,
    input  logic       rgs,
    input  logic       left,
    input  logic       right,
    output logic       power,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic       turn_left_light,
    output logic       turn_right_light
);
    // state        | meaning
    // NOT_STARTING | engine idle or off, no motion
    // STARTING     | clutch engaged, ready to move
    // MOVING       | driving forward or backward depending on rgs
    typedef enum logic [1:0] {
        NOT_STARTING = 2'b00,
        STARTING     = 2'b01,
        MOVING       = 2'b10
    } drive_t;

    localparam int HW = $clog2(POWER_ON_HOLD + 1);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(POWER_ON_HOLD - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    drive_t        state_q, state_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic [BW-1:0] blink_cnt, blink_d;
    logic          phase, phase_d;
    logic          rgs_q;
    logic          power_d;
    logic          stall;
    logic          rgs_chg;
    logic          turn_ok;
    logic [3:0]    moving_d;
    logic          left_light_d, right_light_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            power            <= 1'b0;
            state_q          <= NOT_STARTING;
            hold_cnt         <= '0;
            blink_cnt        <= '0;
            phase            <= 1'b0;
            rgs_q            <= 1'b0;
            moving_state     <= 4'b0000;
            turn_left_light  <= 1'b0;
            turn_right_light <= 1'b0;
        end else begin
            power            <= power_d;
            state_q          <= state_d;
            hold_cnt         <= hold_d;
            blink_cnt        <= blink_d;
            phase            <= phase_d;
            rgs_q            <= rgs;
            moving_state     <= moving_d;
            turn_left_light  <= left_light_d;
            turn_right_light <= right_light_d;
        end
    end

    always_comb begin
        power_d       = power;
        state_d       = state_q;
        hold_d        = hold_cnt;
        blink_d       = blink_cnt;
        phase_d       = phase;
        stall         = 1'b0;
        rgs_chg       = (rgs != rgs_q);
        turn_ok       = 1'b0;
        moving_d      = 4'b0000;
        left_light_d  = 1'b0;
        right_light_d = 1'b0;

        if (!power) begin
            state_d = NOT_STARTING;
            // Blink phase also restarts so the first flash after power-up is predictable.
            blink_d = '0;
            phase_d = 1'b0;
            if (power_on) begin
                if (hold_cnt == HOLD_LAST) begin
                    power_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_cnt + 1'b1;
                end
            end else begin
                hold_d = '0;
            end
        end else begin
            hold_d = '0;
            if (blink_cnt == BLINK_LAST) begin
                blink_d = '0;
                phase_d = ~phase;
            end else begin
                blink_d = blink_cnt + 1'b1;
            end

            if (power_off) begin
                stall = 1'b1;
            end else begin
                case (state_q)
                    NOT_STARTING: begin
                        if (throttle && clutch) state_d = STARTING;
                        else if (throttle)      stall   = 1'b1;
                    end
                    STARTING: begin
                        if (brake)                    state_d = NOT_STARTING;
                        else if (rgs_chg && !clutch)  stall   = 1'b1;
                        else if (throttle && !clutch) state_d = MOVING;
                    end
                    MOVING: begin
                        if (brake)                   state_d = NOT_STARTING;
                        else if (rgs_chg && !clutch) stall   = 1'b1;
                        else if (clutch || !throttle) state_d = STARTING;
                    end
                    default: state_d = NOT_STARTING;
                endcase
            end

            if (stall) begin
                power_d = 1'b0;
                state_d = NOT_STARTING;
            end
        end

        turn_ok     = power_d && (state_d != NOT_STARTING);
        moving_d[0] = turn_ok && left && !right;
        moving_d[1] = turn_ok && right && !left;
        moving_d[2] = (state_d == MOVING) && !rgs;
        moving_d[3] = (state_d == MOVING) && rgs;

        left_light_d  = moving_d[0] && phase_d;
        right_light_d = moving_d[1] && phase_d;
    end

    assign state = state_q;

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Scoreboarded bench for manual_drive_ctrl: directed drive scenarios followed by biased
// random panel activity, checked cycle by cycle against a behavioural model.
module tb_manual_drive_ctrl;
    localparam int HOLD  = 4;
    localparam int BLINK = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       power_on = 1'b0, power_off = 1'b0, clutch = 1'b0, throttle = 1'b0;
    logic       brake = 1'b0, rgs = 1'b0, left = 1'b0, right = 1'b0;
    logic       power;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic       turn_left_light, turn_right_light;

    always #5 clk = ~clk;

    manual_drive_ctrl #(.POWER_ON_HOLD(HOLD), .BLINK_HALF(BLINK)) dut (
        .clk(clk), .rst(rst), .power_on(power_on), .power_off(power_off),
        .clutch(clutch), .throttle(throttle), .brake(brake), .rgs(rgs),
        .left(left), .right(right), .power(power), .state(state),
        .moving_state(moving_state), .turn_left_light(turn_left_light),
        .turn_right_light(turn_right_light)
    );

    int total = 0;
    int bad   = 0;
    int cycle_no = 0;
    logic [8:0] exp_q[$];

    // Reference model: plain integers describing the car, advanced once per clock.
    int m_power = 0, m_state = 0, m_hold = 0, m_blink = 0, m_phase = 0, m_rgs_q = 0;

    // Stimulus vector layout: {rst, power_on, power_off, clutch, throttle, brake, rgs, left, right}
    task automatic model_step(input logic [8:0] v);
        int n_power, n_state, stall, chg;
        logic fwd, bwd, tl, tr, ll, rl;
        logic [8:0] e;
        if (v[8]) begin
            m_power = 0; m_state = 0; m_hold = 0; m_blink = 0; m_phase = 0; m_rgs_q = 0;
            e = '0;
        end else begin
            chg = (v[2] != m_rgs_q) ? 1 : 0;
            n_power = m_power;
            n_state = m_state;
            stall = 0;
            if (m_power == 0) begin
                n_state = 0;
                m_blink = 0;
                m_phase = 0;
                if (v[7]) begin
                    m_hold = m_hold + 1;
                    if (m_hold == HOLD) begin
                        n_power = 1;
                        m_hold = 0;
                    end
                end else begin
                    m_hold = 0;
                end
            end else begin
                m_hold = 0;
                m_blink = m_blink + 1;
                if (m_blink == BLINK) begin
                    m_blink = 0;
                    m_phase = 1 - m_phase;
                end
                if (v[6]) stall = 1;
                else if (m_state == 0) begin
                    if (v[4] && v[5]) n_state = 1;
                    else if (v[4]) stall = 1;
                end else if (m_state == 1) begin
                    if (v[3]) n_state = 0;
                    else if (chg == 1 && !v[5]) stall = 1;
                    else if (v[4] && !v[5]) n_state = 2;
                end else begin
                    if (v[3]) n_state = 0;
                    else if (chg == 1 && !v[5]) stall = 1;
                    else if (v[5] || !v[4]) n_state = 1;
                end
                if (stall == 1) begin
                    n_power = 0;
                    n_state = 0;
                end
            end
            m_power = n_power;
            m_state = n_state;
            m_rgs_q = v[2] ? 1 : 0;
            fwd = (m_state == 2) && !v[2];
            bwd = (m_state == 2) && v[2];
            tl  = (m_power == 1) && (m_state != 0) && v[1] && !v[0];
            tr  = (m_power == 1) && (m_state != 0) && v[0] && !v[1];
            ll  = tl && (m_phase == 1);
            rl  = tr && (m_phase == 1);
            e = {1'(m_power), 2'(m_state), bwd, fwd, tr, tl, ll, rl};
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [8:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            {rst, power_on, power_off, clutch, throttle, brake, rgs, left, right} = v;
            model_step(v);
        end
    endtask

    // Monitor: every edge presents a new output word; compare it with the oldest expectation.
    initial begin
        logic [8:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {power, state, moving_state, turn_left_light, turn_right_light};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d actual pwr/st/mv/ll/rl=%b required=%b",
                             cycle_no, a, e);
                end
            end
        end
    end

    initial begin
        logic [8:0] v;
        logic r;
        // reset, then a too-short start press, then a full one
        cyc(9'b1_0000_0000, 2);
        cyc(9'b0_1000_0000, 3);
        cyc(9'b0_0000_0000, 1);
        cyc(9'b0_1000_0000, 4);
        cyc(9'b0_0000_0000, 1);
        // start, move, reverse under clutch, then reverse without clutch stalls
        cyc(9'b0_0011_0000, 1);
        cyc(9'b0_0001_0000, 2);
        cyc(9'b0_0011_0100, 1);
        cyc(9'b0_0001_0100, 2);
        cyc(9'b0_0001_0000, 2);
        // throttle without clutch from idle stalls
        cyc(9'b0_1000_0000, 4);
        cyc(9'b0_0001_0000, 2);
        // turning, both indicators, then brake
        cyc(9'b0_1000_0000, 4);
        cyc(9'b0_0011_0000, 1);
        cyc(9'b0_0001_0000, 1);
        cyc(9'b0_0001_0010, 9);
        cyc(9'b0_0001_0011, 2);
        cyc(9'b0_0001_0001, 4);
        cyc(9'b0_0000_1010, 2);
        // power_off beats brake and throttle
        cyc(9'b0_1000_0000, 4);
        cyc(9'b0_0011_0000, 1);
        cyc(9'b0_0001_0000, 1);
        cyc(9'b0_0101_1000, 2);
        // power_on while running is ignored; reset mid-motion
        cyc(9'b0_1000_0000, 4);
        cyc(9'b0_0011_0000, 1);
        cyc(9'b0_1001_0010, 3);
        cyc(9'b1_0001_0010, 1);
        cyc(9'b0_0000_0000, 1);

        r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) r = ~r;
            v[8] = ($urandom_range(199) == 0);
            v[7] = ($urandom_range(1) == 0);
            v[6] = ($urandom_range(63) == 0);
            v[5] = ($urandom_range(1) == 0);
            v[4] = ($urandom_range(3) != 0);
            v[3] = ($urandom_range(7) == 0);
            v[2] = r;
            v[1] = ($urandom_range(2) == 0);
            v[0] = ($urandom_range(2) == 0);
            cyc(v, 1);
        end

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
